fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of `async_fifo` among `NUM_REQ` producers in the write clock domain. It grants the port round-robin in bursts of up to `MAX_BURST` words and drives `wr_en`/`wr_data` into the FIFO. It back-pressures producers with the FIFO's `full` flag. It sits directly in front of the FIFO write side; producers use a valid/ready/last handshake.

---
 rtl/fifo_wr_arbiter_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 96 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Modulo increment of a round-robin pointer over num entries.
  function automatic int rr_next(input int ptr, input int num);
    return (ptr + 1 >= num) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer handshake and FIFO write-port bundle
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          half_full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;

  modport master (
    input  req_valid, req_last, req_data, full, half_full,
    output req_ready, wr_en, wr_data
  );

  modport slave (
    output req_valid, req_last, req_data, full, half_full,
    input  req_ready, wr_en, wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - first valid requester at or after the pointer, with wrap
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GNT_W-1:0]   rr_ptr,
  output logic               pick_valid,
  output logic [GNT_W-1:0]   pick_id
);

  int j;

  // Scan from the farthest offset down so the nearest valid one wins last.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    j          = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[GNT_W'(j)]) begin
        pick_valid = 1'b1;
        pick_id    = GNT_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int GNT_W      = $clog2(NUM_REQ),
  parameter int BCNT_W     = $clog2(MAX_BURST)
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst_n,
  fifo_wr_arbiter_if.master    bus,
  output logic [GNT_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 throttled
);

  localparam int CW = BCNT_W + 1;

  arb_state_t       state, state_n;
  logic [GNT_W-1:0] rr_ptr;
  logic [GNT_W-1:0] pick_id;
  logic             pick_valid;
  logic [CW-1:0]    bcnt;
  logic [CW-1:0]    cap;
  logic             accept;
  logic             burst_end;
  logic             grant_load;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_picker (
    .req_valid  (bus.req_valid),
    .rr_ptr     (rr_ptr),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  assign cap  = throttled ? CW'(MAX_BURST / 2) : CW'(MAX_BURST);
  assign busy = (state == BURST);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n       = state;
    grant_load    = 1'b0;
    burst_end     = 1'b0;
    accept        = 1'b0;
    bus.req_ready = '0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    case (state)
      IDLE: begin
        if (pick_valid && !bus.full) begin
          grant_load = 1'b1;
          state_n    = BURST;
        end
      end
      BURST: begin
        bus.req_ready[grant_id] = !bus.full;
        accept      = bus.req_valid[grant_id] && !bus.full;
        bus.wr_en   = accept;
        bus.wr_data = bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        // Without an accept and with full low, the granted producer left a gap.
        if (accept) burst_end = bus.req_last[grant_id] || (bcnt + 1'b1 == cap);
        else        burst_end = !bus.full;
        if (burst_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      bcnt      <= '0;
      throttled <= 1'b0;
    end else begin
      if (grant_load) begin
        grant_id  <= pick_id;
        bcnt      <= '0;
        throttled <= bus.half_full;
      end else if (accept) begin
        bcnt <= bcnt + 1'b1;
      end
      if (burst_end) rr_ptr <= GNT_W'(rr_next(int'(grant_id), NUM_REQ));
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  typedef struct packed { logic l; logic [DW-1:0] d; } word_t;
  typedef struct packed { int c; logic [1:0] g; logic [DW-1:0] d; } wlog_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy, throttled;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk    (clk),
    .wr_rst_n  (rst_n),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .throttled (throttled)
  );

  always #5 clk = ~clk;

  word_t          q[N][$];
  wlog_t          wlog[$];
  int             blen[$];
  bit             hold[N];
  logic [N-1:0]   v, lst;
  logic [DW-1:0]  dd[N];
  logic           f, hf;
  int             n_vec = 0, n_err = 0;
  int             cyc, gap_pct, full_lo, full_hi, hf_lo, hf_hi;
  bit             rnd;
  bit             m_busy, m_thr, prev_busy;
  int             m_g, m_ptr, m_cnt, dut_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() == 0) hold[i] = 1'b0;
      else if (!hold[i] && ($urandom_range(0, 99) >= gap_pct)) hold[i] = 1'b1;
      v[i]   = hold[i];
      dd[i]  = hold[i] ? q[i][0].d : '0;
      lst[i] = hold[i] ? q[i][0].l : 1'b0;
      bus.req_data[i*DW +: DW] = dd[i];
    end
    if (rnd) begin
      f  = ($urandom_range(0, 99) < 20);
      hf = ($urandom_range(0, 99) < 30);
    end else begin
      f  = (cyc >= full_lo) && (cyc < full_hi);
      hf = (cyc >= hf_lo) && (cyc < hf_hi);
    end
    bus.req_valid = v;
    bus.req_last  = lst;
    bus.full      = f;
    bus.half_full = hf;
  endtask

  task automatic observe();
    logic [N-1:0] exp_rdy;
    exp_rdy = (m_busy && !f) ? (N'(1) << m_g) : '0;
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_g);
    chk("throttled", throttled, m_thr);
    chk("wr_en", bus.wr_en, m_busy && v[m_g] && !f);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("wr_data", bus.wr_data, m_busy ? dd[m_g] : '0);
    if (bus.wr_en) begin
      wlog.push_back('{c: cyc, g: grant_id, d: bus.wr_data});
      dut_len++;
    end
    if (prev_busy && !busy) begin
      blen.push_back(dut_len);
      dut_len = 0;
    end
    prev_busy = busy;
  endtask

  // Reference behaviour: round-robin grant, capped bursts, stall on full, end on last/cap/gap.
  task automatic model_step();
    bit found, done;
    int j, cap;
    if (!m_busy) begin
      if ((|v) && !f) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && v[j]) begin
            m_g   = j;
            found = 1'b1;
          end
        end
        m_cnt  = 0;
        m_thr  = hf;
        m_busy = 1'b1;
      end
    end else begin
      cap  = m_thr ? MB / 2 : MB;
      done = 1'b0;
      if (v[m_g] && !f) begin
        m_cnt++;
        done = lst[m_g] || (m_cnt == cap);
        void'(q[m_g].pop_front());
        hold[m_g] = 1'b0;
      end else if (!f) begin
        done = 1'b1;
      end
      if (done) begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % N;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      drive();
      @(negedge clk);
      observe();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      hold[i] = 1'b0;
    end
    wlog.delete();
    blen.delete();
    m_busy = 0; m_thr = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
    prev_busy = 0; dut_len = 0; cyc = 0; rnd = 0; gap_pct = 0;
    full_lo = 0; full_hi = 0; hf_lo = 0; hf_hi = 0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    bus.full = 1'b0; bus.half_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_thr", throttled, 1'b0);
    chk("rst_gnt", grant_id, 2'd0);
    chk("rst_we", bus.wr_en, 1'b0);
    chk("rst_rdy", bus.req_ready, 4'd0);
    chk("rst_wd", bus.wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] log_g(input int i);
    return (i < wlog.size()) ? 64'(wlog[i].g) : 64'hDEAD;
  endfunction
  function automatic logic [63:0] log_c(input int i);
    return (i < wlog.size()) ? 64'(wlog[i].c) : 64'hDEAD;
  endfunction
  function automatic logic [63:0] log_d(input int i);
    return (i < wlog.size()) ? 64'(wlog[i].d) : 64'hDEAD;
  endfunction
  function automatic logic [63:0] blen_at(input int i);
    return (i < blen.size()) ? 64'(blen[i]) : 64'hDEAD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t1_g[5], t1_c[5], t2_c[5];
    logic [DW-1:0] t1_d[5];
    t1_g = '{0, 0, 0, 1, 0};
    t1_c = '{1, 2, 3, 5, 7};
    t1_d = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hA3};
    t2_c = '{1, 3, 5, 7, 9};

    // Short packets: one-cycle arbitration, back-to-back beats, pointer advance.
    do_reset();
    q[0].push_back({1'b0, 32'hA0});
    q[0].push_back({1'b0, 32'hA1});
    q[0].push_back({1'b1, 32'hA2});
    q[0].push_back({1'b1, 32'hA3});
    q[1].push_back({1'b1, 32'hB0});
    run(10);
    chk("t1_nwr", wlog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_g", log_g(i), t1_g[i]);
      chk("t1_c", log_c(i), t1_c[i]);
      chk("t1_d", log_d(i), t1_d[i]);
    end

    // All producers continuously valid with one-word packets.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) q[i].push_back({1'b1, 32'(32'h200 + i * 16 + k)});
    run(12);
    for (int i = 0; i < 5; i++) begin
      chk("t2_g", log_g(i), i % N);
      chk("t2_c", log_c(i), t2_c[i]);
    end

    // Long stream without last: cap splits it into 16/16/8.
    do_reset();
    for (int k = 0; k < 40; k++) q[2].push_back({1'b0, 32'(32'h3000 + k)});
    run(50);
    chk("t3_nwr", wlog.size(), 40);
    chk("t3_b0", blen_at(0), 16);
    chk("t3_b1", blen_at(1), 16);
    chk("t3_b2", blen_at(2), 8);
    for (int i = 0; i < 40; i++) begin
      chk("t3_g", log_g(i), 2);
      chk("t3_d", log_d(i), 32'h3000 + i);
    end

    // Full stalls mid-burst for five cycles.
    do_reset();
    for (int k = 0; k < 10; k++) q[1].push_back({(k == 9), 32'(32'h4000 + k)});
    full_lo = 3; full_hi = 8;
    run(20);
    chk("t4_nwr", wlog.size(), 10);
    chk("t4_c2", log_c(2), 8);
    chk("t4_c9", log_c(9), 15);
    chk("t4_b0", blen_at(0), 10);
    for (int i = 0; i < 10; i++) chk("t4_d", log_d(i), 32'h4000 + i);

    // Half-full at grant halves the cap.
    do_reset();
    for (int k = 0; k < 20; k++) q[3].push_back({1'b0, 32'(32'h5000 + k)});
    hf_lo = 0; hf_hi = 1;
    run(30);
    chk("t5_b0", blen_at(0), 8);
    chk("t5_b1", blen_at(1), 12);
    chk("t5_nwr", wlog.size(), 20);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int k = 0; k < 10; k++) q[0].push_back({1'b0, 32'(32'h6000 + k)});
    run(4);
    drive();
    #1;
    chk("t6_pre_we", bus.wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_we", bus.wr_en, 1'b0);
    chk("t6_rdy", bus.req_ready, 4'd0);
    chk("t6_busy", busy, 1'b0);
    do_reset();
    run(3);

    // Randomized traffic with gaps, full and half_full, then drain.
    do_reset();
    rnd = 1; gap_pct = 25;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 99) < 10) begin
          int len;
          len = $urandom_range(1, 24);
          for (int w = 0; w < len; w++) q[i].push_back({(w == len - 1), 32'($urandom)});
        end
      end
      run(1);
    end
    rnd = 0; gap_pct = 0;
    full_lo = 0; full_hi = 0; hf_lo = 0; hf_hi = 0;
    run(500);
    for (int i = 0; i < N; i++) chk("drain_q", q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
